stm_gain_reader: RTL and testbench

Read-side engine for the gain-STM BRAM. On a start pulse it fetches one gain pattern (all transducers for a given STM index and segment) through the 64-bit read port of the STM memory and streams it out as one transducer per clock in transducer order, to feed the silencer/PWM datapath. It is the counterpart of the 16-bit CPU write path: the writer fills pattern pages, and this block drains one pattern per request.

---
 rtl/stm_gain_reader.sv | 181 ++++++++++++++++++
 tb/tb_stm_gain_reader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stm_gain_reader.sv
// ---------------------------------------------------------------------------
// stm_gain_reader
//
// Read-side engine for the gain-STM BRAM. A start pulse fetches one gain
// pattern (every transducer of one STM index in one memory segment) through
// the 64-bit BRAM read port. The pattern is streamed out one transducer per
// clock, in transducer order, to feed the silencer/PWM datapath.
//
// Each 64-bit word holds four transducers. Lane k is bits [16k+15:16k].
// Within a lane, [7:0] is the phase and [15:8] is the intensity.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_start        request pulse, sampled only while o_busy = 0
//   i_idx[9:0]     STM pattern index, latched on an accepted start
//   i_segment      memory segment, latched on an accepted start
//   o_mem_addr     BRAM read address {idx, word[5:0]}
//   o_mem_segment  segment select for the BRAM read mux
//   i_mem_data     BRAM read data, fixed 2-cycle latency from o_mem_addr
//   o_intensity    intensity of the current transducer
//   o_phase        phase of the current transducer
//   o_tr_idx       index of the current transducer
//   o_valid        o_intensity / o_phase / o_tr_idx valid this cycle
//   o_busy         a pattern read is in progress
//   o_done         one-cycle pulse coincident with the last o_valid
// ---------------------------------------------------------------------------
module stm_gain_reader #(
  parameter int NUM_TRANSDUCERS = 249
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [9:0]  i_idx,
  input  logic        i_segment,
  output logic [15:0] o_mem_addr,
  output logic        o_mem_segment,
  input  logic [63:0] i_mem_data,
  output logic [7:0]  o_intensity,
  output logic [7:0]  o_phase,
  output logic [7:0]  o_tr_idx,
  output logic        o_valid,
  output logic        o_busy,
  output logic        o_done
);

  localparam int NUM_WORDS = (NUM_TRANSDUCERS + 3) / 4;

  // Index of the final word of a pattern.
  localparam logic [5:0] LAST_WORD = 6'(NUM_WORDS - 1);

  // r_cnt counts edges since the accepted start. r_cnt holds k-1 at edge
  // E0+k. Transducer t is launched at edge E0+3+t, so the value of r_cnt
  // at that edge is t+2.
  localparam logic [8:0] LAST_OUT_CNT = 9'(NUM_TRANSDUCERS + 1);
  localparam logic [8:0] LAST_CNT     = 9'(NUM_TRANSDUCERS + 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]  r_state;
  logic [8:0]  r_cnt;
  logic [15:0] r_mem_addr;
  logic        r_mem_segment;
  logic [63:0] r_lanes;
  logic [7:0]  r_intensity;
  logic [7:0]  r_phase;
  logic [7:0]  r_tr_idx;
  logic        r_valid;
  logic        r_done;

  logic [7:0]  w_t;
  logic [1:0]  w_lane;
  logic        w_emit;
  logic [63:0] w_word;
  logic [15:0] w_lane_data;
  logic [5:0]  w_next_word;
  logic        w_issue;

  // Transducer launched at this edge, and its lane within its word.
  assign w_t    = r_cnt[7:0] - 8'd2;
  assign w_lane = w_t[1:0];

  // Output is active from the first returned word through the last real
  // transducer. Lanes beyond NUM_TRANSDUCERS-1 in the final word fall
  // outside this window, so they are never emitted.
  assign w_emit = (r_state != S_IDLE) && (r_cnt >= 9'd2) &&
                  (r_cnt <= LAST_OUT_CNT);

  // Lane 0 is taken directly off the BRAM bus in the cycle the word
  // arrives. This keeps the stream free of bubbles. Lanes 1..3 come from
  // the copy captured at that same edge.
  assign w_word      = (w_lane == 2'd0) ? i_mem_data : r_lanes;
  assign w_lane_data = w_word[{w_lane, 4'b0000} +: 16];

  // The next word is issued every fourth edge (E0+4w). This gives each
  // word exactly the two BRAM cycles plus one capture cycle before its
  // lane 0 is needed.
  assign w_next_word = r_mem_addr[5:0] + 6'd1;
  assign w_issue     = (r_state == S_RUN) && (r_cnt[1:0] == 2'd3) &&
                       (r_mem_addr[5:0] != LAST_WORD);

  // Control FSM: accepts a request, walks the read address through the
  // pattern's words, and returns to idle once the stream is drained. The
  // address register is left holding the last issued address until the
  // next accepted start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= 9'd0;
      r_mem_addr    <= 16'd0;
      r_mem_segment <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mem_addr    <= {i_idx, 6'd0};
            r_mem_segment <= i_segment;
            r_cnt         <= 9'd0;
            r_state       <= (LAST_WORD == 6'd0) ? S_FLUSH : S_RUN;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + 9'd1;
          if (w_issue) begin
            r_mem_addr[5:0] <= w_next_word;
            if (w_next_word == LAST_WORD) begin
              r_state <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          r_cnt <= r_cnt + 9'd1;
          if (r_cnt == LAST_CNT) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Output stage: launches one transducer per cycle while the window is
  // open. Data outputs hold their last value when o_valid is low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lanes     <= 64'd0;
      r_intensity <= 8'd0;
      r_phase     <= 8'd0;
      r_tr_idx    <= 8'd0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      if (w_emit) begin
        r_valid     <= 1'b1;
        r_tr_idx    <= w_t;
        r_intensity <= w_lane_data[15:8];
        r_phase     <= w_lane_data[7:0];
        r_done      <= (r_cnt == LAST_OUT_CNT);
        if (w_lane == 2'd0) begin
          r_lanes <= i_mem_data;
        end
      end
    end
  end

  assign o_mem_addr    = r_mem_addr;
  assign o_mem_segment = r_mem_segment;
  assign o_intensity   = r_intensity;
  assign o_phase       = r_phase;
  assign o_tr_idx      = r_tr_idx;
  assign o_valid       = r_valid;
  assign o_done        = r_done;
  assign o_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_stm_gain_reader.sv
// ---------------------------------------------------------------------------
// tb_stm_gain_reader
//
// Directed bench for stm_gain_reader. A behavioural 2-cycle BRAM builds
// each word from a closed-form pattern of (segment, idx, transducer). Every
// accepted start pushes the expected stream onto a scoreboard. Each entry
// holds the cycle it must appear in, its index, its data and its done flag.
// Every negative edge pops and compares whatever the DUT emits.
// ---------------------------------------------------------------------------
module tb_stm_gain_reader;

  localparam int NT = 249;

  logic        clk = 1'b0;
  logic        rstN;
  logic        start;
  logic [9:0]  idx;
  logic        seg;
  logic [15:0] memAddr;
  logic        memSegment;
  logic [63:0] memData;
  logic [7:0]  intensity;
  logic [7:0]  phase;
  logic [7:0]  trIdx;
  logic        valid;
  logic        busy;
  logic        done;

  typedef struct {
    int         cyc;
    logic [7:0] t;
    logic [7:0] inten;
    logic [7:0] ph;
    logic       done;
  } expItem_t;

  expItem_t    sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        ffSeg0 = 1'b0;
  logic        addrChk = 1'b0;
  logic [9:0]  chkIdx = 10'd0;
  logic        chkSeg = 1'b0;
  int          e0Cyc = 0;
  logic [16:0] rdAddr;

  always #5 clk = ~clk;

  // Reference pattern held in the memory for a given segment / index.
  function automatic logic [7:0] expIntensity(input logic s, input logic [9:0] ix, input int t);
    return 8'(t + 3 * int'(ix) + 17 * int'(s));
  endfunction

  function automatic logic [7:0] expPhase(input logic [9:0] ix, input int t);
    return ~(8'(t)) ^ ix[7:0];
  endfunction

  // Lanes past the last transducer carry a marker that must never appear.
  // Segment 0 can be flooded with 0xFF to prove that segment selection works.
  function automatic logic [63:0] memWord(input logic s, input logic [15:0] a);
    logic [63:0] w;
    logic [15:0] lane;
    int          t;
    w = 64'd0;
    for (int k = 0; k < 4; k++) begin
      t = int'(a[5:0]) * 4 + k;
      if (t >= NT) lane = 16'hABCD;
      else if (!s && ffSeg0) lane = 16'hFFFF;
      else lane = {expIntensity(s, a[15:6], t), expPhase(a[15:6], t)};
      w[16*k +: 16] = lane;
    end
    return w;
  endfunction

  // Two-stage BRAM read pipeline
  always @(posedge clk) begin
    rdAddr  <= {memSegment, memAddr};
    memData <= memWord(rdAddr[16], rdAddr[15:0]);
  end

  stm_gain_reader #(.NUM_TRANSDUCERS(NT)) dut (
    .i_clk         (clk),
    .i_rst_n       (rstN),
    .i_start       (start),
    .i_idx         (idx),
    .i_segment     (seg),
    .o_mem_addr    (memAddr),
    .o_mem_segment (memSegment),
    .i_mem_data    (memData),
    .o_intensity   (intensity),
    .o_phase       (phase),
    .o_tr_idx      (trIdx),
    .o_valid       (valid),
    .o_busy        (busy),
    .o_done        (done)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pushRun(input logic s, input logic [9:0] ix, input int firstCyc);
    expItem_t e;
    for (int t = 0; t < NT; t++) begin
      e.cyc   = firstCyc + t;
      e.t     = 8'(t);
      e.inten = expIntensity(s, ix, t);
      e.ph    = expPhase(ix, t);
      e.done  = (t == NT - 1);
      sb.push_back(e);
    end
  endtask

  task automatic monitorCycle();
    expItem_t e;
    int       k;
    int       w;
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_valid", 64'(valid), 64'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("valid_cycle", 64'(cyc), 64'(e.cyc));
        checkOutput("tr_idx", 64'(trIdx), 64'(e.t));
        checkOutput("intensity", 64'(intensity), 64'(e.inten));
        checkOutput("phase", 64'(phase), 64'(e.ph));
        checkOutput("done", 64'(done), 64'(e.done));
      end
    end else begin
      checkOutput("done_without_valid", 64'(done), 64'd0);
    end
    if (addrChk) begin
      k = cyc - e0Cyc;
      if (k >= 0) begin
        w = k / 4;
        if (w > 62) w = 62;
        checkOutput("mem_addr", 64'(memAddr), 64'({chkIdx, 6'(w)}));
        checkOutput("mem_segment", 64'(memSegment), 64'(chkSeg));
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    monitorCycle();
  endtask

  // Single-cycle start pulse from an idle DUT. Afterwards idx and segment
  // are scrambled, so any late sampling of them would show up as bad data.
  task automatic applyStimulus(input logic s, input logic [9:0] ix);
    start  = 1'b1;
    idx    = ix;
    seg    = s;
    chkIdx = ix;
    chkSeg = s;
    e0Cyc  = cyc + 1;
    pushRun(s, ix, cyc + 4);
    tick();
    start = 1'b0;
    idx   = 10'($urandom);
    seg   = 1'($urandom);
  endtask

  task automatic drain(input int maxCyc);
    for (int i = 0; i < maxCyc && sb.size() > 0; i++) tick();
    checkOutput("stream_complete", 64'(sb.size()), 64'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_addr"}, 64'(memAddr), 64'd0);
    checkOutput({tag, "_seg"}, 64'(memSegment), 64'd0);
    checkOutput({tag, "_valid"}, 64'(valid), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_intensity"}, 64'(intensity), 64'd0);
    checkOutput({tag, "_phase"}, 64'(phase), 64'd0);
    checkOutput({tag, "_tr_idx"}, 64'(trIdx), 64'd0);
  endtask

  initial begin
    int c;
    rstN  = 1'b0;
    start = 1'b0;
    idx   = 10'd0;
    seg   = 1'b0;
    tick();
    tick();
    checkAllZero("reset");
    rstN = 1'b1;
    tick();
    tick();

    // Index 0, segment 0: full stream, 3-cycle latency, done on the last
    $display("[TB] run idx 0 seg 0");
    applyStimulus(1'b0, 10'd0);
    checkOutput("busy_after_start", 64'(busy), 64'd1);
    checkOutput("no_early_valid", 64'(valid), 64'd0);
    drain(300);
    tick();
    checkOutput("busy_after_done", 64'(busy), 64'd0);
    checkOutput("valid_after_done", 64'(valid), 64'd0);
    checkOutput("tr_idx_hold", 64'(trIdx), 64'd248);

    // Index 1023, segment 1, with segment 0 flooded: address walk and segment
    $display("[TB] run idx 1023 seg 1");
    ffSeg0  = 1'b1;
    addrChk = 1'b1;
    applyStimulus(1'b1, 10'd1023);
    drain(300);
    repeat (4) tick();
    checkOutput("addr_hold", 64'(memAddr), 64'hFFFE);
    addrChk = 1'b0;
    ffSeg0  = 1'b0;

    // Start re-pulsed mid-run with a different index: must be ignored
    $display("[TB] run idx 3 with ignored restart");
    addrChk = 1'b1;
    applyStimulus(1'b0, 10'd3);
    c = e0Cyc - 1;
    while (cyc < c + 54) tick();
    checkOutput("tr_idx_at_restart", 64'(trIdx), 64'd50);
    start = 1'b1;
    idx   = 10'd7;
    tick();
    start = 1'b0;
    drain(300);
    tick();
    addrChk = 1'b0;

    // Reset in the middle of a stream
    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 10'd9);
    c = e0Cyc - 1;
    while (cyc < c + 104) tick();
    checkOutput("tr_idx_before_reset", 64'(trIdx), 64'd100);
    rstN = 1'b0;
    #1;
    checkAllZero("async_reset");
    sb.delete();
    tick();
    tick();
    rstN = 1'b1;
    repeat (4) tick();
    checkAllZero("post_reset_idle");
    applyStimulus(1'b0, 10'd5);
    drain(300);
    tick();

    // Start held high: back-to-back runs with a single idle cycle between
    $display("[TB] start held high");
    start = 1'b1;
    idx   = 10'd2;
    seg   = 1'b1;
    c     = cyc;
    pushRun(1'b1, 10'd2, c + 4);
    pushRun(1'b1, 10'd2, c + 257);
    while (cyc < c + 253) tick();
    checkOutput("busy_gap", 64'(busy), 64'd0);
    tick();
    checkOutput("busy_rerun", 64'(busy), 64'd1);
    while (cyc < c + 300) tick();
    start = 1'b0;
    drain(400);
    repeat (5) tick();
    checkOutput("busy_final", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
